window_line_ctrl: RTL and testbench

- Sequences the WIN_SIZE-1 line-buffer RAMs (dual-port, 1-cycle registered read, read-first on same-address read/write) of a 2-D sliding-window filter.
- For each incoming raster pixel it writes the pixel into the oldest line buffer and reads the same column from every line buffer.
- It reassembles a vertical column of WIN_SIZE pixels, ordered by line age, for the downstream window/kernel stage.
- Sits between the pixel source and the window shift-register array.

---
 rtl/window_line_ctrl.sv | 136 +++++++++++++
 tb/tb_window_line_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/window_line_ctrl.sv
// window_line_ctrl: line-buffer sequencer for a 2-D sliding-window filter.
// Each valid raster pixel is written into the oldest of the WIN_SIZE-1 line
// buffers. The same column is read from every buffer, and the vertical column
// of WIN_SIZE pixels is rebuilt in line-age order for the window stage.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   sof_i                 start of frame (qualified by data_valid_i)
//   data_i, data_valid_i  input pixel and strobe (no backpressure)
//   ram_wr_en_o           one-hot write enable per line buffer (combinational)
//   ram_wr_addr_o         shared write address (combinational)
//   ram_wr_data_o         shared write data (combinational)
//   ram_rd_en_o           shared read enable (combinational)
//   ram_rd_addr_o         shared read address (combinational)
//   ram_rd_data_i         read data, slice b from buffer b (1-cycle latency)
//   column_o              slot k = pixel of line y-k, slot 0 in the LSBs
//   column_valid_o        column_o valid, one pulse per gated pixel
//   eol_o                 column is the last of its line
module window_line_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned WIN_SIZE   = 3,
  parameter int unsigned ADDR_WIDTH = $clog2(LINE_WIDTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                sof_i,
  input  logic [DATA_WIDTH-1:0]               data_i,
  input  logic                                data_valid_i,
  output logic [WIN_SIZE-2:0]                 ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]               ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0]               ram_wr_data_o,
  output logic                                ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0]               ram_rd_addr_o,
  input  logic [(WIN_SIZE-1)*DATA_WIDTH-1:0]  ram_rd_data_i,
  output logic [WIN_SIZE*DATA_WIDTH-1:0]      column_o,
  output logic                                column_valid_o,
  output logic                                eol_o
);

  localparam int unsigned NBUF   = WIN_SIZE - 1;
  localparam int unsigned PTR_W  = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int unsigned LCNT_W = $clog2(WIN_SIZE);

  logic [ADDR_WIDTH-1:0] col_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LCNT_W-1:0]     line_cnt;

  logic                  sof_v;
  logic [ADDR_WIDTH-1:0] eff_col;
  logic [PTR_W-1:0]      eff_ptr;
  logic [LCNT_W-1:0]     eff_lcnt;
  logic                  last_col;
  logic [ADDR_WIDTH-1:0] col_nxt;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [LCNT_W-1:0]     lcnt_nxt;

  logic [DATA_WIDTH-1:0] slot0_q;
  logic [PTR_W-1:0]      ptr_d;
  int unsigned           src;

  // A valid sof pixel overrides the running counters with a fresh frame origin.
  always_comb begin
    sof_v    = sof_i & data_valid_i;
    eff_col  = sof_v ? '0 : col_cnt;
    eff_ptr  = sof_v ? '0 : wr_ptr;
    eff_lcnt = sof_v ? '0 : line_cnt;
    last_col = (eff_col == ADDR_WIDTH'(LINE_WIDTH - 1));
  end

  // Counter successors: column wraps, buffer pointer rotates, line count saturates.
  always_comb begin
    col_nxt  = last_col ? '0 : eff_col + ADDR_WIDTH'(1);
    ptr_nxt  = eff_ptr;
    lcnt_nxt = eff_lcnt;
    if (last_col) begin
      ptr_nxt = (eff_ptr == PTR_W'(NBUF - 1)) ? '0 : eff_ptr + PTR_W'(1);
      if (eff_lcnt != LCNT_W'(NBUF)) begin
        lcnt_nxt = eff_lcnt + LCNT_W'(1);
      end
    end
  end

  // RAM ports act in the same cycle as the pixel strobe.
  always_comb begin
    ram_rd_en_o   = data_valid_i;
    ram_rd_addr_o = eff_col;
    ram_wr_addr_o = eff_col;
    ram_wr_data_o = data_i;
    ram_wr_en_o   = data_valid_i ? ((NBUF)'(1) << eff_ptr) : '0;
  end

  // Position state, advanced once per valid pixel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      col_cnt  <= '0;
      wr_ptr   <= '0;
      line_cnt <= '0;
    end else if (data_valid_i) begin
      col_cnt  <= col_nxt;
      wr_ptr   <= ptr_nxt;
      line_cnt <= lcnt_nxt;
    end
  end

  // Output pipeline stage aligned with the 1-cycle RAM read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot0_q        <= '0;
      ptr_d          <= '0;
      eol_o          <= 1'b0;
      column_valid_o <= 1'b0;
    end else begin
      column_valid_o <= data_valid_i && (eff_lcnt == LCNT_W'(NBUF));
      if (data_valid_i) begin
        slot0_q <= data_i;
        ptr_d   <= eff_ptr;
        eol_o   <= last_col;
      end
    end
  end

  // Age-order rotation: the buffer just written (ptr_d) holds the oldest line,
  // so slot k reads buffer (ptr_d - k) mod NBUF. Upper slots follow the RAM
  // output register, which holds while no read is issued.
  always_comb begin
    src      = 0;
    column_o = '0;
    column_o[DATA_WIDTH-1:0] = slot0_q;
    for (int unsigned k = 1; k < WIN_SIZE; k++) begin
      src = (32'(ptr_d) + NBUF - k) % NBUF;
      column_o[k*DATA_WIDTH +: DATA_WIDTH] = ram_rd_data_i[src*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_window_line_ctrl.sv
// tb_window_line_ctrl: directed bench for window_line_ctrl with WIN_SIZE=3,
// LINE_WIDTH=4. Models the two line-buffer RAMs (read-first, registered read)
// and checks RAM control, column contents, gating and reset behaviour.
module tb_window_line_ctrl;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int WS = 3;
  localparam int AW = 2;
  localparam int NB = WS - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sof;
  logic [DW-1:0]       data;
  logic                valid;
  logic [NB-1:0]       wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [NB*DW-1:0]    rd_data;
  logic [WS*DW-1:0]    column;
  logic                column_valid;
  logic                eol;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  window_line_ctrl #(
    .DATA_WIDTH(DW), .LINE_WIDTH(LW), .WIN_SIZE(WS), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .sof_i          (sof),
    .data_i         (data),
    .data_valid_i   (valid),
    .ram_wr_en_o    (wr_en),
    .ram_wr_addr_o  (wr_addr),
    .ram_wr_data_o  (wr_data),
    .ram_rd_en_o    (rd_en),
    .ram_rd_addr_o  (rd_addr),
    .ram_rd_data_i  (rd_data),
    .column_o       (column),
    .column_valid_o (column_valid),
    .eol_o          (eol)
  );

  // Line-buffer model: read-first dual port, registered read data.
  logic [DW-1:0] mem  [NB][LW];
  logic [DW-1:0] rd_q [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rd_en) rd_q[b] <= mem[b][rd_addr];
      if (wr_en[b]) mem[b][wr_addr] <= wr_data;
    end
  end

  assign rd_data = {rd_q[1], rd_q[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pv(input int base, input int fl, input int col);
    return 8'((((base + fl) & 15) << 4) | col);
  endfunction

  // Reset held for 3 cycles; outputs must clear immediately and stay clear.
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    sof   = 1'b0;
    repeat (3) begin
      #1;
      check("rst_col_valid", 32'(column_valid), 32'(0));
      check("rst_eol", 32'(eol), 32'(0));
      check("rst_slot0", 32'(column[DW-1:0]), 32'(0));
      check("rst_wr_en", 32'(wr_en), 32'(0));
      check("rst_rd_en", 32'(rd_en), 32'(0));
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid = 1'b0;
    sof   = 1'b0;
    #1;
    check("idle_wr_en", 32'(wr_en), 32'(0));
    check("idle_rd_en", 32'(rd_en), 32'(0));
    @(posedge clk);
    #1;
    check("idle_col_valid", 32'(column_valid), 32'(0));
  endtask

  // Drive one pixel, check RAM-side controls, then step past the clock edge.
  task automatic send(input logic [DW-1:0] d, input bit s, input logic [NB-1:0] exp_wr, input int col);
    @(negedge clk);
    data  = d;
    sof   = s;
    valid = 1'b1;
    #1;
    check("wr_en", 32'(wr_en), 32'(exp_wr));
    check("rd_en", 32'(rd_en), 32'(1));
    check("wr_addr", 32'(wr_addr), 32'(col));
    check("rd_addr", 32'(rd_addr), 32'(col));
    check("wr_data", 32'(wr_data), 32'(d));
    @(posedge clk);
    #1;
  endtask

  // Stream columns c0..c1-1 of frame line fl; expected column from the pixel formula.
  task automatic stream_line(input int base, input int fl, input bit first_sof,
                             input bit gaps, input int c0, input int c1);
    for (int col = c0; col < c1; col++) begin
      if (gaps) repeat ($urandom_range(0, 5)) idle_cycle();
      send(pv(base, fl, col), first_sof && (col == c0), (fl % 2 == 0) ? 2'b01 : 2'b10, col);
      check("col_valid", 32'(column_valid), 32'(fl >= 2));
      if (fl >= 2) begin
        check("column", 32'(column),
              32'({pv(base, fl - 2, col), pv(base, fl - 1, col), pv(base, fl, col)}));
        check("eol", 32'(eol), 32'(col == LW - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int b = 0; b < NB; b++) begin
      rd_q[b] = '0;
      for (int a = 0; a < LW; a++) mem[b][a] = 8'hEE;
    end
    rst_n = 1'b0;
    sof   = 1'b0;
    valid = 1'b0;
    data  = '0;

    reset_pulse();
    idle_cycle();
    idle_cycle();

    // Frame A: back-to-back pixels, pixel = line*16 + col.
    stream_line(0, 0, 1'b1, 1'b0, 0, 4);
    stream_line(0, 1, 1'b0, 1'b0, 0, 4);
    stream_line(0, 2, 1'b0, 1'b0, 0, 2);
    check("A_l2c1_column", 32'(column), 32'(24'h011121));
    check("A_l2c1_eol", 32'(eol), 32'(0));
    stream_line(0, 2, 1'b0, 1'b0, 2, 4);
    stream_line(0, 3, 1'b0, 1'b0, 0, 4);
    check("A_l3c3_column", 32'(column), 32'(24'h132333));
    check("A_l3c3_eol", 32'(eol), 32'(1));
    stream_line(0, 4, 1'b0, 1'b0, 0, 4);
    idle_cycle();

    // Frame B: sof mid-frame, line 2 with random gaps, then sof at line 3 col 2.
    stream_line(8, 0, 1'b1, 1'b0, 0, 4);
    stream_line(8, 1, 1'b0, 1'b0, 0, 4);
    stream_line(8, 2, 1'b0, 1'b1, 0, 4);
    idle_cycle();
    stream_line(8, 3, 1'b0, 1'b0, 0, 2);

    // Frame C starts on the next pixel, column 2 of the old line.
    stream_line(4, 0, 1'b1, 1'b0, 0, 4);
    stream_line(4, 1, 1'b0, 1'b0, 0, 4);
    stream_line(4, 2, 1'b0, 1'b0, 0, 2);

    // Reset mid-line 2, asserted right after a valid column.
    reset_pulse();

    // Frame D without sof: reset alone must restart line state.
    stream_line(12, 0, 1'b0, 1'b0, 0, 4);
    stream_line(12, 1, 1'b0, 1'b0, 0, 4);
    stream_line(12, 2, 1'b0, 1'b0, 0, 4);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
